// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared fetch-stage types, widths and offset helper         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam int PC_W    = 32;
  localparam int IMEM_AW = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } pc_src_t;

  // Word offset to byte offset: sign-extend the immediate and scale by 4.
  function automatic logic [PC_W-1:0] br_offset(input logic [15:0] off);
    return {{(PC_W-18){off[15]}}, off, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_unit_if : redirect controls in, fetch address/status out    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int IMEM_AW = 5
);
  logic               stall;
  logic               branch_taken;
  logic [15:0]        branch_off;
  logic               jump;
  logic [25:0]        jump_target;
  logic               jump_reg;
  logic [PC_W-1:0]    jr_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic               fetch_valid;
  logic               fault;
  logic [31:0]        fetch_count;

  modport master (
    output stall, branch_taken, branch_off, jump, jump_target, jump_reg, jr_addr,
    input  imem_addr, pc, pc_plus4, fetch_valid, fault, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_off, jump, jump_target, jump_reg, jr_addr,
    output imem_addr, pc, pc_plus4, fetch_valid, fault, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_pc_sel : priority mux JR > J > BR > SEQ with target arithmetic  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int PC_W = mips_pkg::PC_W
) (
  input  wire logic [PC_W-1:0] i_pc_plus4,
  input  wire logic            i_branch_taken,
  input  wire logic [15:0]     i_branch_off,
  input  wire logic            i_jump,
  input  wire logic [25:0]     i_jump_target,
  input  wire logic            i_jump_reg,
  input  wire logic [PC_W-1:0] i_jr_addr,
  output pc_src_t              o_src,
  output logic      [PC_W-1:0] o_cand
);

  logic [PC_W-1:0] w_br_target;
  logic [PC_W-1:0] w_j_target;

  assign w_br_target = i_pc_plus4 + PC_W'(br_offset(i_branch_off));
  assign w_j_target  = {i_pc_plus4[PC_W-1:28], i_jump_target, 2'b00};

  always_comb begin
    o_src  = SEQ;
    o_cand = i_pc_plus4;
    if (i_jump_reg) begin
      o_src  = JR;
      o_cand = i_jr_addr;
    end else if (i_jump) begin
      o_src  = J;
      o_cand = w_j_target;
    end else if (i_branch_taken) begin
      o_src  = BR;
      o_cand = w_br_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_unit : PC register, RUN/FAULT FSM, range check, fetch count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter int              PC_W     = mips_pkg::PC_W,
  parameter int              IMEM_AW  = mips_pkg::IMEM_AW,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fetch_pc_unit_if.slave    bus
);

  localparam logic [PC_W-1:0] C_LAST_WORD = PC_W'((1 << IMEM_AW) - 4);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fault;
  logic            r_fetch_valid;
  logic [31:0]     r_count;

  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_cand;
  pc_src_t         w_src;
  logic            w_misalign;
  logic            w_out_of_range;
  logic            w_bad;

  assign w_pc_plus4 = r_pc + PC_W'(4);

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .i_pc_plus4     (w_pc_plus4),
    .i_branch_taken (bus.branch_taken),
    .i_branch_off   (bus.branch_off),
    .i_jump         (bus.jump),
    .i_jump_target  (bus.jump_target),
    .i_jump_reg     (bus.jump_reg),
    .i_jr_addr      (bus.jr_addr),
    .o_src          (w_src),
    .o_cand         (w_cand)
  );

  // PC is always word-aligned, so only a register-sourced target can be misaligned.
  assign w_misalign     = (w_src == JR) && (w_cand[1:0] != 2'b00);
  assign w_out_of_range = (w_cand > C_LAST_WORD) || (w_cand[PC_W-1:IMEM_AW] != '0);
  assign w_bad          = w_misalign || w_out_of_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_fault       <= 1'b0;
      r_fetch_valid <= 1'b1;
      r_count       <= 32'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!bus.stall) begin
            if (w_bad) begin
              r_state       <= FAULT;
              r_fault       <= 1'b1;
              r_fetch_valid <= 1'b0;
            end else begin
              r_pc <= w_cand;
              if (r_count != 32'hFFFF_FFFF) begin
                r_count <= r_count + 32'd1;
              end
            end
          end
        end
        FAULT: begin
          r_fault       <= 1'b1;
          r_fetch_valid <= 1'b0;
        end
        default: begin
          r_state       <= FAULT;
          r_fault       <= 1'b1;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.imem_addr   = r_pc[IMEM_AW-1:0];
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.fault       = r_fault;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_pc_unit : directed vector table plus fault/reset sequences  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;

  fetch_pc_unit_if #(.PC_W(32), .IMEM_AW(5)) bus ();

  fetch_pc_unit #(.PC_W(32), .IMEM_AW(5), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] tgt;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  int n_vec;
  int n_err;
  vec_t tbl [14];

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] o,
                              input logic jj, input logic [25:0] t, input logic r,
                              input logic [31:0] ra, input logic [31:0] p, input logic [31:0] c);
    vec_t v;
    v.stall = s; v.br = b; v.off = o; v.j = jj; v.tgt = t; v.jr = r; v.jra = ra;
    v.e_pc = p; v.e_cnt = c;
    return v;
  endfunction

  task automatic drv(input logic s, input logic b, input logic [15:0] o,
                     input logic jj, input logic [25:0] t, input logic r, input logic [31:0] ra);
    bus.stall        = s;
    bus.branch_taken = b;
    bus.branch_off   = o;
    bus.jump         = jj;
    bus.jump_target  = t;
    bus.jump_reg     = r;
    bus.jr_addr      = ra;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] e_pc, input logic e_fault,
                       input logic e_valid, input logic [31:0] e_cnt);
    logic [31:0] e_p4;
    logic [4:0]  e_ia;
    e_p4 = e_pc + 32'd4;
    e_ia = e_pc[4:0];
    n_vec++;
    if (bus.pc !== e_pc) begin
      n_err++; $display("FAIL %s pc got %h expected %h", nm, bus.pc, e_pc);
    end
    if (bus.imem_addr !== e_ia) begin
      n_err++; $display("FAIL %s imem_addr got %h expected %h", nm, bus.imem_addr, e_ia);
    end
    if (bus.pc_plus4 !== e_p4) begin
      n_err++; $display("FAIL %s pc_plus4 got %h expected %h", nm, bus.pc_plus4, e_p4);
    end
    if (bus.fault !== e_fault) begin
      n_err++; $display("FAIL %s fault got %b expected %b", nm, bus.fault, e_fault);
    end
    if (bus.fetch_valid !== e_valid) begin
      n_err++; $display("FAIL %s fetch_valid got %b expected %b", nm, bus.fetch_valid, e_valid);
    end
    if (bus.fetch_count !== e_cnt) begin
      n_err++; $display("FAIL %s fetch_count got %0d expected %0d", nm, bus.fetch_count, e_cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //           stall br off       j  tgt    jr jra     e_pc  e_cnt
    tbl[0]  = mk(0, 0, 16'h0000, 0, 26'h0, 0, 32'd0,  32'd4,  32'd1);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 26'h0, 0, 32'd0,  32'd8,  32'd2);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 26'h0, 0, 32'd0,  32'd12, 32'd3);
    tbl[3]  = mk(0, 1, 16'h0003, 1, 26'h1, 0, 32'd0,  32'd4,  32'd4);
    tbl[4]  = mk(0, 1, 16'h0002, 0, 26'h0, 0, 32'd0,  32'd16, 32'd5);
    tbl[5]  = mk(0, 1, 16'hFFFD, 0, 26'h0, 0, 32'd0,  32'd8,  32'd6);
    tbl[6]  = mk(1, 0, 16'h0000, 0, 26'h0, 1, 32'd20, 32'd8,  32'd6);
    tbl[7]  = mk(1, 0, 16'h0000, 0, 26'h0, 1, 32'd20, 32'd8,  32'd6);
    tbl[8]  = mk(1, 0, 16'h0000, 0, 26'h0, 1, 32'd20, 32'd8,  32'd6);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 26'h0, 1, 32'd20, 32'd20, 32'd7);
    tbl[10] = mk(0, 0, 16'h0000, 1, 26'h7, 1, 32'd12, 32'd12, 32'd8);
    tbl[11] = mk(0, 1, 16'h0100, 1, 26'h2, 0, 32'd0,  32'd8,  32'd9);
    tbl[12] = mk(0, 0, 16'h0000, 1, 26'h1, 0, 32'd0,  32'd4,  32'd10);
    tbl[13] = mk(1, 0, 16'h0000, 0, 26'h0, 1, 32'd6,  32'd4,  32'd10);

    rst_n = 1'b0;
    drv(0, 0, 16'h0, 0, 26'h0, 0, 32'd0);
    step();
    rst_n = 1'b1;
    check("reset", 32'd0, 1'b0, 1'b1, 32'd0);

    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].stall, tbl[i].br, tbl[i].off, tbl[i].j, tbl[i].tgt, tbl[i].jr, tbl[i].jra);
      step();
      check($sformatf("vec%0d", i), tbl[i].e_pc, 1'b0, 1'b1, tbl[i].e_cnt);
    end

    // Misaligned register target from pc=4 faults and freezes everything.
    drv(0, 0, 16'h0, 0, 26'h0, 1, 32'd6);
    step();
    check("jr_misalign", 32'd4, 1'b1, 1'b0, 32'd10);
    drv(0, 0, 16'h0, 1, 26'h3, 0, 32'd0);
    step();
    check("fault_hold", 32'd4, 1'b1, 1'b0, 32'd10);

    // Reset wins over a pending jump while in FAULT.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("fault_reset", 32'd0, 1'b0, 1'b1, 32'd0);

    drv(0, 0, 16'h0, 0, 26'h0, 0, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("walk%0d", k), 32'(4 * k), 1'b0, 1'b1, 32'(k));
    end
    step();
    check("range_top", 32'd28, 1'b1, 1'b0, 32'd7);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("reset2", 32'd0, 1'b0, 1'b1, 32'd0);

    drv(0, 1, 16'hFFFF, 0, 26'h0, 0, 32'd0);
    step();
    check("br_back_to_0", 32'd0, 1'b0, 1'b1, 32'd1);

    drv(0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0100);
    step();
    check("jr_upper_bits", 32'd0, 1'b1, 1'b0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
